rtc_shadow_regfile: RTL and testbench

//  Parametrised RTC register bank with shadow/active copies. Host writes land in shadow; a commit pulse

---
 rtl/rtc_regfile_pkg.sv | 19 +
 rtl/rtc_shadow_regfile_if.sv | 50 +++++
 rtl/rtc_irq_sync.sv | 30 +++
 rtl/rtc_shadow_regfile.sv | 199 +++++++++++++++++++
 tb/tb_rtc_shadow_regfile.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/rtc_regfile_pkg.sv
// Shared types and constants for the RTC shadow/active register bank.
// Holds the scan FSM state encoding and the bit positions used in the
// two status words (IRQ status and busy/dirty status).
package rtc_regfile_pkg;

    // Scan FSM: IDLE waits for a commit, SCAN walks every register index once.
    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } scan_state_t;

    // Bit positions inside the IRQ status word (STAT_ADDR).
    localparam int STAT_PEND  = 0;

    // Bit positions inside the read-only busy/dirty word (STAT_ADDR+1).
    localparam int STAT_BUSY  = 0;
    localparam int STAT_DIRTY = 1;

endpackage : rtc_regfile_pkg

// File: rtl/rtc_shadow_regfile_if.sv
// Bus bundle between the RTC bus controller / display formatter (master side)
// and the shadow register bank (slave side).
//
// Signalling: wr_en, commit and rd_en are single-cycle strobes qualified by
// the rising clock edge; there is no back-pressure, every strobe is consumed
// in the cycle it is seen. rd_valid is a one-cycle pulse one clock after each
// rd_en and qualifies rd_data, which otherwise holds its last value. busy is
// a level that is high for the whole copy scan. scan_state mirrors the scan
// FSM for debug visibility.
interface rtc_shadow_regfile_if #(
    parameter int DW = 8,
    parameter int AW = 4
) ();
    import rtc_regfile_pkg::*;

    // Host write side
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          commit;
    logic          busy;

    // Display read side
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;
    logic          rd_valid;

    // Interrupt path
    logic          irq_in;
    logic          irq_pend;

    // Debug view of the scan FSM
    scan_state_t   scan_state;

    modport master (
        output wr_en, wr_addr, wr_data, commit,
        output rd_en, rd_addr,
        output irq_in,
        input  busy, rd_data, rd_valid, irq_pend, scan_state
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, commit,
        input  rd_en, rd_addr,
        input  irq_in,
        output busy, rd_data, rd_valid, irq_pend, scan_state
    );

endinterface : rtc_shadow_regfile_if

// File: rtl/rtc_irq_sync.sv
// Two-flop synchroniser for the asynchronous RTC interrupt line followed by
// a rising-edge detector. The sticky pending bit lives in the parent so that
// the write-1-to-clear logic stays next to the register map.
module rtc_irq_sync (
    input  logic clk,
    input  logic reset,
    input  logic irq_in,
    output logic rise
);

    logic meta;
    logic sync;
    logic sync_d;

    // Synchroniser chain plus one delayed copy for edge detection.
    always_ff @(posedge clk) begin
        if (reset) begin
            meta   <= 1'b0;
            sync   <= 1'b0;
            sync_d <= 1'b0;
        end else begin
            meta   <= irq_in;
            sync   <= meta;
            sync_d <= sync;
        end
    end

    assign rise = sync & ~sync_d;

endmodule : rtc_irq_sync

// File: rtl/rtc_shadow_regfile.sv
// RTC register bank with shadow and active copies.
// Host writes land in the shadow bank and mark the entry dirty. A commit
// pulse launches a scan that visits every index once (NREG cycles) and copies
// dirty entries into the active bank, which is what the display path reads.
// Also hosts a sticky interrupt-pending bit (W1C at STAT_ADDR) and a read-only
// busy/dirty status word at STAT_ADDR+1.
//
// Build option RTC_REGFILE_BYPASS_EN: when defined, a read of the index being
// copied in the same cycle returns the incoming shadow value; otherwise it
// returns the old active value and the new value appears on the next read.
module rtc_shadow_regfile
    import rtc_regfile_pkg::*;
#(
    parameter int DW        = 8,
    parameter int AW        = 4,
    parameter int NREG      = 16,
    parameter int STAT_ADDR = 10
) (
    input  logic                 clk,
    input  logic                 reset,
    rtc_shadow_regfile_if.slave  bus
);

    localparam logic [AW:0]   NREG_L   = (AW+1)'(NREG);
    localparam logic [AW-1:0] STAT_A   = AW'(STAT_ADDR);
    localparam logic [AW-1:0] STAT_B   = AW'(STAT_ADDR + 1);
    localparam logic [AW-1:0] LAST_IDX = AW'(NREG - 1);

    scan_state_t   state;
    scan_state_t   state_nxt;
    logic [AW-1:0] idx;
    logic [AW-1:0] idx_nxt;

    logic [DW-1:0] shadow [NREG];
    logic [DW-1:0] active [NREG];
    logic [NREG-1:0] dirty;

    logic          busy;
    logic          copy_en;
    logic          wr_in_range;
    logic          rd_in_range;
    logic          wr_store;
    logic          w1c;
    logic          irq_rise;
    logic          irq_pend;
    logic [DW-1:0] rd_word;
    logic [DW-1:0] rd_data;
    logic          rd_valid;

    // ------------------------------------------------------------------
    // Scan FSM
    // ------------------------------------------------------------------

    // State and scan index registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            idx   <= '0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
        end
    end

    // Next-state logic: commits are ignored while a scan is running.
    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        case (state)
            IDLE: begin
                if (bus.commit) begin
                    state_nxt = SCAN;
                    idx_nxt   = '0;
                end
            end
            SCAN: begin
                if (idx == LAST_IDX) begin
                    state_nxt = IDLE;
                    idx_nxt   = '0;
                end else begin
                    idx_nxt = idx + AW'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
                idx_nxt   = '0;
            end
        endcase
    end

    assign busy    = (state == SCAN);
    assign copy_en = busy && dirty[idx];

    // ------------------------------------------------------------------
    // Write decode
    // ------------------------------------------------------------------
    assign wr_in_range = ({1'b0, bus.wr_addr} < NREG_L);
    assign rd_in_range = ({1'b0, bus.rd_addr} < NREG_L);
    assign wr_store    = bus.wr_en && wr_in_range &&
                         (bus.wr_addr != STAT_A) && (bus.wr_addr != STAT_B);
    assign w1c         = bus.wr_en && (bus.wr_addr == STAT_A) &&
                         bus.wr_data[STAT_PEND];

    // Shadow bank and dirty flags. The host write is placed after the scan
    // clear so a write to the index being scanned keeps its dirty flag set.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) begin
                shadow[i] <= '0;
            end
            dirty <= '0;
        end else begin
            if (copy_en) begin
                dirty[idx] <= 1'b0;
            end
            if (wr_store) begin
                shadow[bus.wr_addr] <= bus.wr_data;
                dirty[bus.wr_addr]  <= 1'b1;
            end
        end
    end

    // Active bank: only the scan ever writes it, one dirty entry per cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) begin
                active[i] <= '0;
            end
        end else if (copy_en) begin
            active[idx] <= shadow[idx];
        end
    end

    // ------------------------------------------------------------------
    // Interrupt pending
    // ------------------------------------------------------------------
    rtc_irq_sync u_irq_sync (
        .clk    (clk),
        .reset  (reset),
        .irq_in (bus.irq_in),
        .rise   (irq_rise)
    );

    // Sticky pending bit; a new edge takes priority over a simultaneous clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            irq_pend <= 1'b0;
        end else if (irq_rise) begin
            irq_pend <= 1'b1;
        end else if (w1c) begin
            irq_pend <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Read path
    // ------------------------------------------------------------------

    // Read mux: status words take priority over the storage array.
    always_comb begin
        rd_word = '0;
        if (bus.rd_addr == STAT_A) begin
            rd_word[STAT_PEND] = irq_pend;
        end else if (bus.rd_addr == STAT_B) begin
            rd_word[STAT_DIRTY] = |dirty;
            rd_word[STAT_BUSY]  = busy;
        end else if (rd_in_range) begin
`ifdef RTC_REGFILE_BYPASS_EN
            if (copy_en && (bus.rd_addr == idx)) begin
                rd_word = shadow[bus.rd_addr];
            end else begin
                rd_word = active[bus.rd_addr];
            end
`else
            rd_word = active[bus.rd_addr];
`endif
        end
    end

    // Registered read data with a one-cycle valid pulse; data holds otherwise.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= bus.rd_en;
            if (bus.rd_en) begin
                rd_data <= rd_word;
            end
        end
    end

    assign bus.busy       = busy;
    assign bus.rd_data    = rd_data;
    assign bus.rd_valid   = rd_valid;
    assign bus.irq_pend   = irq_pend;
    assign bus.scan_state = state;

endmodule : rtc_shadow_regfile

// File: tb/tb_rtc_shadow_regfile.sv
// Self-checking bench for rtc_shadow_regfile: directed scenarios followed by
// a randomized phase, all compared against a behavioural register-map model.
module tb_rtc_shadow_regfile;
    import rtc_regfile_pkg::*;

    localparam int DW        = 8;
    localparam int AW        = 4;
    localparam int NREG      = 16;
    localparam int STAT_ADDR = 10;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    rtc_shadow_regfile_if #(.DW(DW), .AW(AW)) bus ();

    rtc_shadow_regfile #(
        .DW(DW), .AW(AW), .NREG(NREG), .STAT_ADDR(STAT_ADDR)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // ---------------- reference model ----------------
    logic [DW-1:0] m_sh   [NREG];
    logic [DW-1:0] m_act  [NREG];
    bit            m_dirty[NREG];
    int            m_scan;          // index copied at the next edge, -1 when idle
    bit            m_pend;
    bit [3:1]      m_hist;          // irq_in as sampled 1, 2, 3 edges ago
    logic [DW-1:0] m_rd_data;
    bit            m_rd_valid;

    int total = 0;
    int bad   = 0;

`ifdef RTC_REGFILE_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    function automatic logic [DW-1:0] model_read(input int a);
        logic [DW-1:0] v;
        bit any;
        v   = '0;
        any = 1'b0;
        if (a == STAT_ADDR) begin
            v[0] = m_pend;
        end else if (a == STAT_ADDR + 1) begin
            for (int i = 0; i < NREG; i++) any |= m_dirty[i];
            v[1] = any;
            v[0] = (m_scan >= 0);
        end else if (a < NREG) begin
            v = m_act[a];
            if (BYPASS && m_scan == a && m_dirty[a]) v = m_sh[a];
        end
        return v;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Apply the register-map rules for one clock, advance, then compare.
    task automatic tick();
        int wa;
        int ra;
        wa = int'(bus.wr_addr);
        ra = int'(bus.rd_addr);
        if (reset) begin
            for (int i = 0; i < NREG; i++) begin
                m_sh[i] = '0; m_act[i] = '0; m_dirty[i] = 1'b0;
            end
            m_scan = -1; m_pend = 1'b0; m_hist = '0;
            m_rd_data = '0; m_rd_valid = 1'b0;
        end else begin
            m_rd_valid = bus.rd_en;
            if (bus.rd_en) m_rd_data = model_read(ra);
            if (m_hist[2] && !m_hist[3]) m_pend = 1'b1;
            else if (bus.wr_en && wa == STAT_ADDR && bus.wr_data[0]) m_pend = 1'b0;
            m_hist = {m_hist[2:1], bus.irq_in};
            if (m_scan >= 0) begin
                if (m_dirty[m_scan]) begin
                    m_act[m_scan]   = m_sh[m_scan];
                    m_dirty[m_scan] = 1'b0;
                end
                m_scan = (m_scan == NREG - 1) ? -1 : m_scan + 1;
            end else if (bus.commit) begin
                m_scan = 0;
            end
            if (bus.wr_en && wa < NREG && wa != STAT_ADDR && wa != STAT_ADDR + 1) begin
                m_sh[wa]    = bus.wr_data;
                m_dirty[wa] = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        check("busy",     bus.busy,     m_scan >= 0);
        check("rd_valid", bus.rd_valid, m_rd_valid);
        check("irq_pend", bus.irq_pend, m_pend);
        check("rd_data",  bus.rd_data,  m_rd_data);
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive(input bit we, input int wa, input int wd,
                         input bit cm, input bit re, input int ra);
        bus.wr_en   = we;
        bus.wr_addr = AW'(wa);
        bus.wr_data = DW'(wd);
        bus.commit  = cm;
        bus.rd_en   = re;
        bus.rd_addr = AW'(ra);
        tick();
        bus.wr_en  = 1'b0;
        bus.commit = 1'b0;
        bus.rd_en  = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0);
    endtask

    task automatic wr(input int a, input int d);
        drive(1, a, d, 0, 0, 0);
    endtask

    task automatic rd(input int a);
        drive(0, 0, 0, 0, 1, a);
    endtask

    task automatic cmt();
        drive(0, 0, 0, 1, 0, 0);
    endtask

    // Idle until the scan is about to process index 'target' (bounded).
    task automatic wait_scan(input int target);
        for (int n = 0; n < 40 && m_scan != target; n++) idle(1);
        check("scan_reached", bus.busy, 1'b1);
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        bus.wr_en = 0; bus.wr_addr = '0; bus.wr_data = '0; bus.commit = 0;
        bus.rd_en = 0; bus.rd_addr = '0; bus.irq_in = 0;

        // Reset state
        reset = 1'b1;
        idle(3);
        check("rst_busy",     bus.busy,     1'b0);
        check("rst_rd_valid", bus.rd_valid, 1'b0);
        check("rst_rd_data",  bus.rd_data,  8'h00);
        check("rst_pend",     bus.irq_pend, 1'b0);
        reset = 1'b0;

        // 1: write, commit, full scan, read back
        wr(3, 'h59);
        cmt();
        check("s1_busy_start", bus.busy, 1'b1);
        idle(16);
        check("s1_busy_end", bus.busy, 1'b0);
        rd(3);
        check("s1_rd3", bus.rd_data, 8'h59);
        check("s1_valid", bus.rd_valid, 1'b1);
        idle(1);
        check("s1_valid_pulse", bus.rd_valid, 1'b0);
        check("s1_hold", bus.rd_data, 8'h59);

        // 2: shadow write without commit is invisible; status shows dirty
        wr(3, 'h12);
        rd(3);
        check("s2_rd3_old", bus.rd_data, 8'h59);
        rd(STAT_ADDR + 1);
        check("s2_status", bus.rd_data, 8'h02);

        // 3: writes during a scan (behind and ahead of the scan index)
        cmt();
        wait_scan(2);
        wr(1, 'hAA);
        wr(5, 'hBB);
        idle(20);
        rd(5);
        check("s3_rd5", bus.rd_data, 8'hBB);
        rd(1);
        check("s3_rd1_unchanged", bus.rd_data, 8'h00);
        rd(3);
        check("s3_rd3", bus.rd_data, 8'h12);
        rd(STAT_ADDR + 1);
        check("s3_dirty1", bus.rd_data, 8'h02);

        // 4: interrupt latency, W1C, set beats clear
        bus.irq_in = 1'b1;
        idle(1); check("s4_lat1", bus.irq_pend, 1'b0);
        idle(1); check("s4_lat2", bus.irq_pend, 1'b0);
        idle(1); check("s4_lat3", bus.irq_pend, 1'b1);
        rd(STAT_ADDR);
        check("s4_stat_rd", bus.rd_data, 8'h01);
        wr(STAT_ADDR, 1);
        check("s4_w1c", bus.irq_pend, 1'b0);
        bus.irq_in = 1'b0;
        idle(3);
        bus.irq_in = 1'b1;
        idle(2);
        check("s4_pre_set", bus.irq_pend, 1'b0);
        wr(STAT_ADDR, 1);
        check("s4_set_wins", bus.irq_pend, 1'b1);
        bus.irq_in = 1'b0;

        // 5: reset in the middle of a scan
        wr(0, 'h11);
        wr(4, 'h44);
        wr(9, 'h99);
        cmt();
        wait_scan(7);
        reset = 1'b1;
        idle(1);
        reset = 1'b0;
        check("s5_busy", bus.busy, 1'b0);
        for (int a = 0; a < NREG; a++) begin
            rd(a);
            check("s5_rd_zero", bus.rd_data, 8'h00);
        end

        // 6: read of the index being copied this cycle
        wr(6, 'h3C);
        cmt();
        wait_scan(6);
        rd(6);
        check("s6_same_cycle", bus.rd_data, BYPASS ? 8'h3C : 8'h00);
        idle(12);
        rd(6);
        check("s6_after", bus.rd_data, 8'h3C);

        // 7: randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            bit we, cm, re;
            int wa, wd, ra;
            we = ($urandom_range(0, 2) == 0);
            wa = $urandom_range(0, NREG - 1);
            wd = $urandom_range(0, 255);
            cm = ($urandom_range(0, 24) == 0);
            re = ($urandom_range(0, 1) == 1);
            ra = $urandom_range(0, NREG - 1);
            if ($urandom_range(0, 9) == 0) bus.irq_in = ~bus.irq_in;
            drive(we, wa, wd, cm, re, ra);
        end
        idle(20);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_rtc_shadow_regfile
